// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage encodings, widths and the queued {pc, inst} entry type.
package fetch_unit_pkg;
  localparam int          RV_INST_W = 32;
  localparam int          RV_PC_W   = 32;
  localparam logic [31:0] RV_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_STALL = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [RV_PC_W-1:0]   pc;
    logic [RV_INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [RV_PC_W-1:0] align_pc(input logic [RV_PC_W-1:0] addr);
    return {addr[RV_PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO: a push is visible at dout after the edge; push+pop on full is allowed.
// Flush wins over push; storage is cleared on reset so dout reads zero afterwards.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per cycle into the decode queue.
// Entry valid the cycle after its push; stalls while the queue is full and decode is not ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic [RV_PC_W-1:0]   mem_addr,
  input  logic [RV_INST_W-1:0] mem_inst,
  input  logic                 redirect_valid,
  input  logic [RV_PC_W-1:0]   redirect_target,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [RV_INST_W-1:0] dec_inst,
  output logic [RV_PC_W-1:0]   dec_pc,
  output logic                 halted,
  output logic                 misalign_err
);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [RV_PC_W-1:0]  pc;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                can_fetch;
  fetch_entry_t        entry_in;
  fetch_entry_t        head;

  assign mem_addr  = {2'b00, pc[RV_PC_W-1:2]};
  assign can_fetch = (mem_addr < MEM_LIMIT);
  assign dec_valid = !empty;
  assign pop       = dec_valid && dec_ready;
  assign entry_in  = '{pc: pc, inst: mem_inst};
  assign dec_pc    = head.pc;
  assign dec_inst  = head.inst;

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .din    (entry_in),
    .full   (full),
    .empty  (empty),
    .dout   (head)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= FETCH_RUN;
    else          state <= state_nxt;
  end

  // A redirect restarts fetch from any state, including HALT.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = FETCH_RUN;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (!can_fetch)         state_nxt = FETCH_HALT;
          else if (full && !pop)  state_nxt = FETCH_STALL;
        end
        FETCH_STALL: begin
          if (!can_fetch)         state_nxt = FETCH_HALT;
          else if (pop)           state_nxt = FETCH_RUN;
        end
        FETCH_HALT:               state_nxt = FETCH_HALT;
        default:                  state_nxt = FETCH_RUN;
      endcase
    end
  end

  always_comb begin
    push   = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH_RUN:  push   = !redirect_valid && can_fetch && (!full || pop);
      FETCH_HALT: halted = 1'b1;
      default:    push   = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) pc <= align_pc(redirect_target);
      else if (push)      pc <= pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-mid-run sequence, then random
// traffic checked against an in-order instruction-stream model.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        halted;
  logic        misalign_err;

  logic [31:0] imem [256];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign mem_inst = (mem_addr < 32'd256) ? imem[mem_addr[7:0]] : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(256), .FIFO_DEPTH(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_inst       (mem_inst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_halt;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t v(input logic r, input logic rd, input logic [31:0] t, input logic ev,
                             input logic [31:0] pc, input logic [31:0] a, input logic h, input logic m);
    vec_t x;
    x.ready = r; x.redir = rd; x.target = t; x.exp_valid = ev;
    x.exp_pc = pc; x.exp_addr = a; x.exp_halt = h; x.exp_mis = m;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    logic [31:0] w;
    w = pc >> 2;
    return (w < 32'd256) ? imem[w[7:0]] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic        mis_prev;
    logic        flush_prev;
    logic        rst_now;
    int          pops;

    for (int i = 0; i < 256; i++) imem[i] = $urandom;

    // Columns: ready, redirect, target | valid, pc, mem_addr, halted, misalign (observed before inputs apply)
    vecs[0]  = v(0, 0, 32'h0,   0, 32'h0,   0,   0, 0);
    vecs[1]  = v(0, 0, 32'h0,   1, 32'h0,   1,   0, 0);
    vecs[2]  = v(0, 0, 32'h0,   1, 32'h0,   2,   0, 0);
    vecs[3]  = v(0, 0, 32'h0,   1, 32'h0,   2,   0, 0);
    vecs[4]  = v(0, 0, 32'h0,   1, 32'h0,   2,   0, 0);
    vecs[5]  = v(0, 0, 32'h0,   1, 32'h0,   2,   0, 0);
    vecs[6]  = v(1, 0, 32'h0,   1, 32'h0,   2,   0, 0);
    vecs[7]  = v(1, 0, 32'h0,   1, 32'h4,   2,   0, 0);
    vecs[8]  = v(1, 0, 32'h0,   1, 32'h8,   3,   0, 0);
    vecs[9]  = v(0, 0, 32'h0,   1, 32'hC,   4,   0, 0);
    vecs[10] = v(0, 1, 32'h40,  1, 32'hC,   5,   0, 0);
    vecs[11] = v(1, 0, 32'h0,   0, 32'h0,   16,  0, 0);
    vecs[12] = v(1, 1, 32'h41,  1, 32'h40,  17,  0, 0);
    vecs[13] = v(1, 0, 32'h0,   0, 32'h0,   16,  0, 1);
    vecs[14] = v(1, 0, 32'h0,   1, 32'h40,  17,  0, 0);
    vecs[15] = v(1, 1, 32'h3F8, 1, 32'h44,  18,  0, 0);
    vecs[16] = v(1, 0, 32'h0,   0, 32'h0,   254, 0, 0);
    vecs[17] = v(0, 0, 32'h0,   1, 32'h3F8, 255, 0, 0);
    vecs[18] = v(0, 0, 32'h0,   1, 32'h3F8, 256, 0, 0);
    vecs[19] = v(1, 0, 32'h0,   1, 32'h3F8, 256, 1, 0);
    vecs[20] = v(1, 0, 32'h0,   1, 32'h3FC, 256, 1, 0);
    vecs[21] = v(1, 0, 32'h0,   0, 32'h0,   256, 1, 0);
    vecs[22] = v(1, 1, 32'h0,   0, 32'h0,   256, 1, 0);
    vecs[23] = v(0, 0, 32'h0,   0, 32'h0,   0,   0, 0);
    vecs[24] = v(0, 0, 32'h0,   1, 32'h0,   1,   0, 0);
    vecs[25] = v(0, 0, 32'h0,   1, 32'h0,   2,   0, 0);

    repeat (3) step();
    check("reset_valid",    {31'b0, dec_valid},    32'h0);
    check("reset_inst",     dec_inst,              32'h0);
    check("reset_pc",       dec_pc,                32'h0);
    check("reset_halted",   {31'b0, halted},       32'h0);
    check("reset_misalign", {31'b0, misalign_err}, 32'h0);
    check("reset_mem_addr", mem_addr,              32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      check($sformatf("vec%0d_valid", i),    {31'b0, dec_valid},    {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_mem_addr", i), mem_addr,              vecs[i].exp_addr);
      check($sformatf("vec%0d_halted", i),   {31'b0, halted},       {31'b0, vecs[i].exp_halt});
      check($sformatf("vec%0d_misalign", i), {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i),   dec_pc,   vecs[i].exp_pc);
        check($sformatf("vec%0d_inst", i), dec_inst, inst_at(vecs[i].exp_pc));
      end
      dec_ready       = vecs[i].ready;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].target;
      step();
    end

    // Reset with a full queue and a redirect presented on the same edge.
    check("pre_reset_full", {31'b0, dec_valid}, 32'h1);
    reset_n = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    check("midreset_valid",    {31'b0, dec_valid},    32'h0);
    check("midreset_mem_addr", mem_addr,              32'h0);
    check("midreset_halted",   {31'b0, halted},       32'h0);
    check("midreset_misalign", {31'b0, misalign_err}, 32'h0);
    reset_n = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b1;
    step();
    check("post_reset_valid", {31'b0, dec_valid}, 32'h1);
    check("post_reset_pc",    dec_pc,             32'h0);
    check("post_reset_inst",  dec_inst,           inst_at(32'h0));

    // Random traffic: delivered entries must follow the fetch stream exactly.
    exp_pc = 32'h0; mis_prev = 1'b0; flush_prev = 1'b0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_misalign", {31'b0, misalign_err}, {31'b0, mis_prev});
      if (flush_prev) check("rnd_flush_valid", {31'b0, dec_valid}, 32'h0);
      rst_now         = ($urandom_range(0, 499) == 0);
      reset_n         = !rst_now;
      dec_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 39) == 0);
      redirect_target = $urandom_range(0, 32'h40F);
      if (!rst_now && dec_valid && dec_ready) begin
        check("rnd_in_memory", {31'b0, (exp_pc < 32'h400)}, 32'h1);
        check("rnd_pc",   dec_pc,   exp_pc);
        check("rnd_inst", dec_inst, inst_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rst_now)             exp_pc = 32'h0;
      else if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
      mis_prev   = !rst_now && redirect_valid && (redirect_target[1:0] != 2'b00);
      flush_prev = rst_now || redirect_valid;
      step();
    end
    reset_n = 1'b1; redirect_valid = 1'b0;
    check("rnd_progress", {31'b0, (pops > 500)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
